// File: rtl/collector_pkg.sv
// collector_pkg: shared widths, entry layout and width helpers for the
// result_collector FIFO.
// Optional feature macro: COLLECTOR_TIMESTAMP_EN (adds a timestamp field to each entry).
package collector_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF      = 16;
  localparam int unsigned TS_WIDTH_DEF   = 16;
  localparam int unsigned DROP_CNT_WIDTH = 16;

  localparam int unsigned PTR_WIDTH_DEF  = $clog2(DEPTH_DEF);
  localparam int unsigned CNT_WIDTH_DEF  = PTR_WIDTH_DEF + 1;

  // One stored result at the default widths.
  typedef struct packed {
`ifdef COLLECTOR_TIMESTAMP_EN
    logic [TS_WIDTH_DEF-1:0]   ts;
`endif
    logic [DATA_WIDTH_DEF-1:0] data;
  } collector_entry_t;

  // Pointer width for a given FIFO depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: must be able to hold the value DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/collector_fifo_mem.sv
// collector_fifo_mem: DEPTH x entry register array, one synchronous write
// port and one combinational read port. Contents are not reset.
// Ports:
//   clk   in   clock
//   we    in   write enable
//   waddr in   write address
//   wdata in   write entry
//   raddr in   read address
//   rdata out  read entry (combinational)
module collector_fifo_mem
  import collector_pkg::*;
#(
  parameter type         entry_t = collector_entry_t,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned AW      = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  // Storage write; no reset so the array maps onto plain flops/latches-free regs.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/result_collector.sv
// result_collector: captures every q/q_valid beat from the arithmetic core
// into a show-ahead FIFO and re-presents it on a valid/ready read port.
// Beats arriving while full (and not popped) are dropped and counted.
// Optional feature macro: COLLECTOR_TIMESTAMP_EN (per-entry push timestamp on rd_ts_o;
// without it rd_ts_o is tied to 0).
// Ports:
//   clk_i       in   clock
//   artsn_i     in   async active-low reset
//   q_i         in   result data from the core
//   q_valid_i   in   result beat valid (no backpressure)
//   rd_data_o   out  head entry data (combinational from storage)
//   rd_ts_o     out  head entry timestamp
//   rd_valid_o  out  FIFO not empty
//   rd_ready_i  in   consumer accepts head entry
//   count_o     out  occupancy
//   full_o      out  occupancy == DEPTH
//   empty_o     out  occupancy == 0
//   overflow_o  out  sticky drop indicator
//   drop_cnt_o  out  saturating dropped-beat count
//   clr_ovf_i   in   clears overflow_o and drop_cnt_o
module result_collector
  import collector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned TS_WIDTH   = TS_WIDTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      artsn_i,
  input  logic [DATA_WIDTH-1:0]     q_i,
  input  logic                      q_valid_i,
  output logic [DATA_WIDTH-1:0]     rd_data_o,
  output logic [TS_WIDTH-1:0]       rd_ts_o,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      overflow_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o,
  input  logic                      clr_ovf_i
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned DC_W  = DROP_CNT_WIDTH;

  typedef struct packed {
`ifdef COLLECTOR_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]   ts;
`endif
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic [DC_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic             push;
  logic             pop;
  logic             drop;
  entry_t           wr_entry;
  entry_t           rd_entry;

`ifdef COLLECTOR_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
    end
  end
`endif

  // Handshake decode, occupancy and drop bookkeeping.
  always_comb begin
    pop        = ~empty_q & rd_ready_i;
    push       = q_valid_i & (~full_q | pop);
    drop       = q_valid_i & full_q & ~pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    // A drop in the same cycle as a clear wins: the clear is applied first.
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf_i) begin
        drop_cnt_d = DC_W'(1);
      end else if (drop_cnt_q != {DC_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + DC_W'(1);
      end
    end else if (clr_ovf_i) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = q_i;
`ifdef COLLECTOR_TIMESTAMP_EN
    wr_entry.ts   = ts_q;
`endif
  end

  collector_fifo_mem #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH),
    .AW      (PTR_W)
  ) u_mem (
    .clk   (clk_i),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign rd_data_o  = rd_entry.data;
`ifdef COLLECTOR_TIMESTAMP_EN
  assign rd_ts_o    = rd_entry.ts;
`else
  assign rd_ts_o    = '0;
`endif
  assign rd_valid_o = ~empty_q;
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = ovf_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: directed bench for result_collector with a queue-based
// reference model checked every cycle plus literal expectations from the
// documented scenarios.
module tb_result_collector;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int TSW   = 16;

  logic          clk_i = 1'b0;
  logic          artsn_i;
  logic [DW-1:0] q_i;
  logic          q_valid_i;
  logic [DW-1:0] rd_data_o;
  logic [TSW-1:0] rd_ts_o;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic [4:0]    count_o;
  logic          full_o;
  logic          empty_o;
  logic          overflow_o;
  logic [15:0]   drop_cnt_o;
  logic          clr_ovf_i;

  int total = 0;
  int bad   = 0;

  result_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clk_i      (clk_i),
    .artsn_i    (artsn_i),
    .q_i        (q_i),
    .q_valid_i  (q_valid_i),
    .rd_data_o  (rd_data_o),
    .rd_ts_o    (rd_ts_o),
    .rd_valid_o (rd_valid_o),
    .rd_ready_i (rd_ready_i),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o),
    .clr_ovf_i  (clr_ovf_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a queue of (data, timestamp) plus overflow state.
  typedef struct { logic [31:0] d; int ts; } ent_t;
  ent_t mq[$];
  bit   m_ovf;
  int   m_dc;
  int   m_ts;

  always @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      mq.delete();
      m_ovf = 0;
      m_dc  = 0;
      m_ts  = 0;
    end else begin
      bit pop_m, full_m, push_m, drop_m;
      ent_t e;
      full_m = (mq.size() == DEPTH);
      pop_m  = (mq.size() != 0) && rd_ready_i;
      push_m = q_valid_i && (!full_m || pop_m);
      drop_m = q_valid_i && full_m && !pop_m;
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        e.d  = q_i;
        e.ts = m_ts;
        mq.push_back(e);
      end
      if (drop_m) begin
        m_ovf = 1;
        m_dc  = clr_ovf_i ? 1 : ((m_dc == 65535) ? 65535 : m_dc + 1);
      end else if (clr_ovf_i) begin
        m_ovf = 0;
        m_dc  = 0;
      end
      m_ts = (m_ts + 1) % (1 << TSW);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    if (artsn_i) begin
      chk("rd_valid", 64'(rd_valid_o), 64'(mq.size() != 0));
      chk("count",    64'(count_o),    64'(mq.size()));
      chk("full",     64'(full_o),     64'(mq.size() == DEPTH));
      chk("empty",    64'(empty_o),    64'(mq.size() == 0));
      chk("overflow", 64'(overflow_o), 64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt_o), 64'(m_dc));
      if (mq.size() != 0) begin
        chk("rd_data", 64'(rd_data_o), 64'(mq[0].d));
`ifdef COLLECTOR_TIMESTAMP_EN
        chk("rd_ts", 64'(rd_ts_o), 64'(mq[0].ts));
`endif
      end
`ifndef COLLECTOR_TIMESTAMP_EN
      chk("rd_ts_tied", 64'(rd_ts_o), 64'(0));
`endif
    end
  end

  task automatic step(input logic qv, input logic [31:0] d, input logic rdy, input logic clr);
    q_valid_i  = qv;
    q_i        = d;
    rd_ready_i = rdy;
    clr_ovf_i  = clr;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic fill(input int base);
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 32'(base + i), 1'b0, 1'b0);
  endtask

  initial begin
    artsn_i = 1'b0; q_i = '0; q_valid_i = 1'b0; rd_ready_i = 1'b0; clr_ovf_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_valid", 64'(rd_valid_o), 64'(0));
    chk("rst_empty", 64'(empty_o),    64'(1));
    chk("rst_count", 64'(count_o),    64'(0));
    chk("rst_full",  64'(full_o),     64'(0));
    chk("rst_ovf",   64'(overflow_o), 64'(0));
    chk("rst_dc",    64'(drop_cnt_o), 64'(0));
    artsn_i = 1'b1;

    // Single beat, pushed at the timestamp-3 edge after release.
    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'd19, 1'b0, 1'b0);
    chk("single_valid", 64'(rd_valid_o), 64'(1));
    chk("single_data",  64'(rd_data_o),  64'(19));
    chk("single_count", 64'(count_o),    64'(1));
`ifdef COLLECTOR_TIMESTAMP_EN
    chk("ts_first", 64'(rd_ts_o), 64'(3));
`endif
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("single_empty", 64'(empty_o), 64'(1));
    chk("single_count0", 64'(count_o), 64'(0));
    repeat (2) step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'd23, 1'b0, 1'b0);
`ifdef COLLECTOR_TIMESTAMP_EN
    chk("ts_second", 64'(rd_ts_o), 64'(7));
`endif
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Fill and overflow: 18 beats into 16 entries.
    for (int i = 1; i <= 18; i++) begin
      step(1'b1, 32'(i), 1'b0, 1'b0);
      if (i == 16) chk("fill_full", 64'(full_o), 64'(1));
    end
    chk("fill_ovf", 64'(overflow_o), 64'(1));
    chk("fill_dc",  64'(drop_cnt_o), 64'(2));
    for (int i = 1; i <= 16; i++) begin
      chk("drain_order", 64'(rd_data_o), 64'(i));
      step(1'b0, 32'd0, 1'b1, 1'b0);
    end
    chk("drain_empty", 64'(empty_o), 64'(1));
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("clr_ovf", 64'(overflow_o), 64'(0));

    // Push and pop together while full: no drop, 100 lands at the tail.
    fill(200);
    step(1'b1, 32'd100, 1'b1, 1'b0);
    chk("pp_count", 64'(count_o),    64'(16));
    chk("pp_nodrop", 64'(drop_cnt_o), 64'(0));
    chk("pp_head",  64'(rd_data_o),  64'(202));
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("pp_last", 64'(rd_data_o), 64'(100));
      step(1'b0, 32'd0, 1'b1, 1'b0);
    end

    // Clear coincident with a drop: the drop wins.
    fill(300);
    step(1'b1, 32'd55, 1'b0, 1'b0);
    step(1'b1, 32'd56, 1'b0, 1'b0);
    chk("pre_dc", 64'(drop_cnt_o), 64'(2));
    step(1'b1, 32'd57, 1'b0, 1'b1);
    chk("cd_ovf", 64'(overflow_o), 64'(1));
    chk("cd_dc",  64'(drop_cnt_o), 64'(1));
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("c_ovf", 64'(overflow_o), 64'(0));
    chk("c_dc",  64'(drop_cnt_o), 64'(0));

    // Asynchronous reset with 5 entries held.
    repeat (11) step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("held5", 64'(count_o), 64'(5));
    rd_ready_i = 1'b0;
    @(posedge clk_i);
    #2 artsn_i = 1'b0;
    #1;
    chk("arst_valid", 64'(rd_valid_o), 64'(0));
    chk("arst_count", 64'(count_o),    64'(0));
    chk("arst_empty", 64'(empty_o),    64'(1));
    #1 artsn_i = 1'b1;
    @(negedge clk_i);

    // Drop counter saturation; also carries the timestamp past its wrap.
    fill(400);
    for (int i = 0; i < 65540; i++) step(1'b1, 32'hdead, 1'b0, 1'b0);
    chk("sat_dc", 64'(drop_cnt_o), 64'(16'hffff));
    step(1'b1, 32'hbeef, 1'b0, 1'b0);
    chk("sat_hold", 64'(drop_cnt_o), 64'(16'hffff));
    repeat (16) step(1'b0, 32'd0, 1'b1, 1'b1);
    chk("sat_clr", 64'(drop_cnt_o), 64'(0));
    step(1'b1, 32'd77, 1'b0, 1'b0);
    chk("post_wrap_data", 64'(rd_data_o), 64'(77));
    step(1'b0, 32'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_collector.md
# result_collector

Sink for the arithmetic core's result stream. Captures every `q`/`q_valid` beat the core emits (the core has no backpressure) into a show-ahead FIFO and re-presents the results on a valid/ready read port to a downstream consumer. Sits directly after `top` in the datapath and reports lost results when the consumer falls behind.

## Interface
- `DATA_WIDTH`, 32: result width; must match the core.
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `TS_WIDTH`, 16: timestamp width; used only with `COLLECTOR_TIMESTAMP_EN`.
- `clk_i`  in  1: single clock.
- `artsn_i`  in  1: reset, asynchronous, active-low.
- `q_i`  in  DATA_WIDTH: result from the core.
- `q_valid_i`  in  1: result beat valid; no ready path back to the core.
- `rd_data_o`  out  DATA_WIDTH: head entry.
- `rd_ts_o`  out  TS_WIDTH: timestamp of the head entry.
- `rd_valid_o`  out  1: FIFO not empty.
- `rd_ready_i`  in  1: consumer accepts the head entry.
- `count_o`  out  $clog2(DEPTH)+1: current occupancy.
- `full_o`  out  1: count equals DEPTH.
- `empty_o`  out  1: count is 0.
- `overflow_o`  out  1: sticky; a beat was dropped.
- `drop_cnt_o`  out  16: saturating count of dropped beats.
- `clr_ovf_i`  in  1: clears `overflow_o` and `drop_cnt_o`.

## Operation
- Push: `q_valid_i` high and (not full, or a pop in the same cycle). The entry is written at the write pointer and the write pointer advances.
- Pop: `rd_valid_o && rd_ready_i`. The read pointer advances.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. `count_o` is held in a separate counter of $clog2(DEPTH)+1 bits.
- Simultaneous push and pop: count is unchanged. This is also allowed when full; no drop occurs.
- Simultaneous push and pop when empty: the pop cannot occur (`rd_valid_o` is low); the push proceeds.
- Drop: `q_valid_i` high while full with no pop.
  - The beat is discarded and the FIFO is unchanged.
  - `overflow_o` is set.
  - `drop_cnt_o` increments, saturating at 16'hFFFF.
- `clr_ovf_i` clears `overflow_o` and `drop_cnt_o` to 0. If a drop occurs in the same cycle, the set wins: `overflow_o` = 1 and `drop_cnt_o` = 1.
- `rd_data_o` and `rd_ts_o` read the head entry combinationally from storage. Their value is don't-care while `rd_valid_o` is low.
- The consumer may hold `rd_ready_i` high permanently. `rd_data_o` must stay stable while `rd_valid_o` is high and `rd_ready_i` is low.

## Timing
- Reset values: all outputs 0 except `empty_o` = 1. Pointers and count are 0; storage contents are don't-care.
- Reset asserted mid-operation flushes the FIFO immediately (asynchronously). Pending results are lost; overflow and drop count clear.
- Push-to-read latency is 1 cycle: a beat pushed at edge N into an empty FIFO shows `rd_valid_o` = 1 after edge N.
- Pop takes effect at the edge where `rd_valid_o && rd_ready_i`. The next entry is presented after that edge.
- `count_o`, `full_o`, `empty_o`, `overflow_o` and `drop_cnt_o` are registered and update at the same edge as the push, pop or drop that causes them.
- Full throughput: one push and one pop per cycle, sustained.

## Configuration
- `COLLECTOR_TIMESTAMP_EN` defined:
  - A free-running TS_WIDTH counter resets to 0, increments every cycle and wraps.
  - Each pushed entry stores the counter value of its push cycle.
  - `rd_ts_o` presents the head entry's stored value.
- `COLLECTOR_TIMESTAMP_EN` undefined: no timestamp counter and no timestamp storage; `rd_ts_o` is tied to 0.

## Structure
- Package `collector_pkg`:
  - Default width constants.
  - Entry struct typedef `collector_entry_t` with data, plus timestamp under the macro.
  - Occupancy/pointer width localparams derived from DEPTH.
- Sub-module `collector_fifo_mem`: DEPTH x entry register array with one synchronous write port and one combinational read port, no reset on contents.
- Pointers, count, flags, drop logic and the timestamp counter live in `result_collector`.

## Test plan
- Single beat: after reset, push q=19 (a=10, b=4, c=2, d=1) with `rd_ready_i`=0 -> next cycle `rd_valid_o`=1, `rd_data_o`=19, `count_o`=1. Raise ready for one cycle -> `empty_o`=1, `count_o`=0.
- Fill and overflow: DEPTH=16, push 18 consecutive beats 1..18 with ready low.
  - After beat 16: `full_o`=1.
  - After beats 17 and 18: `overflow_o`=1, `drop_cnt_o`=2.
  - Draining reads 1..16 in order.
- Full push+pop: when full, push 100 while popping -> `count_o` stays 16, no drop, 100 is read last.
- Clear vs drop: `clr_ovf_i` in the same cycle as a drop -> `overflow_o`=1, `drop_cnt_o`=1. Clear alone next cycle -> both 0.
- Reset mid-stream: with 5 entries held, pulse `artsn_i` low between edges -> outputs immediately show `rd_valid_o`=0, `count_o`=0, `empty_o`=1.
- Timestamp (macro on): push at cycles 3 and 7 after reset release -> `rd_ts_o` reads 3 then 7. Run more than 2^TS_WIDTH cycles and confirm the stored value wraps.
